// File: rtl/ddr_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddr_port_arbiter
// Purpose  : Shares one DDR3 controller command port between three masters,
//            using urgent-first round-robin selection and a burst watchdog.
// Revision : 1.0  initial release
// ============================================================================
module ddr_port_arbiter #(
  parameter int unsigned ADDR_W  = 28,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            req_i,
  input  logic [2:0]            urgent_i,
  input  logic [2:0]            wr_i,
  input  logic [3*ADDR_W-1:0]   addr_i,
  input  logic [3*LEN_W-1:0]    len_i,
  output logic [2:0]            gnt_o,
  output logic [2:0]            done_o,
  output logic [1:0]            owner_o,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic                  cmd_wr_o,
  output logic [ADDR_W-1:0]     cmd_addr_o,
  output logic [LEN_W-1:0]      cmd_len_o,
  input  logic                  burst_done_i,
  output logic                  err_timeout_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_BUSY = 2'd2;

  localparam int unsigned         WDOG_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDOG_W-1:0]   WDOG_LAST = WDOG_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        rr_q, rr_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_wr_q, cmd_wr_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [LEN_W-1:0]  cmd_len_q, cmd_len_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              err_q, err_d;
  logic [2:0]        gnt_q, gnt_d;
  logic [2:0]        done_q, done_d;

  logic [2:0]        w_cand;
  logic [1:0]        w_win;
  logic              w_expire;

  // Urgent requests mask out non-urgent ones; otherwise every request competes.
  assign w_cand   = ((req_i & urgent_i) != 3'b000) ? (req_i & urgent_i) : req_i;
  assign w_expire = (TIMEOUT != 0) && (wdog_q == WDOG_LAST);

  // Scan from farthest to nearest so the channel closest to rr_q wins.
  always_comb begin
    w_win = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      int idx;
      idx = (int'(rr_q) + i) % 3;
      if (w_cand[idx]) w_win = 2'(idx);
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    cmd_valid_d = cmd_valid_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    wdog_d      = wdog_q;
    err_d       = err_q;
    gnt_d       = 3'b000;
    done_d      = 3'b000;
    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          state_d     = S_CMD;
          owner_d     = w_win;
          cmd_valid_d = 1'b1;
          cmd_wr_d    = wr_i[w_win];
          cmd_addr_d  = addr_i[w_win*ADDR_W +: ADDR_W];
          cmd_len_d   = len_i[w_win*LEN_W +: LEN_W];
        end
      end
      S_CMD: begin
        if (cmd_ready_i) begin
          state_d     = S_BUSY;
          cmd_valid_d = 1'b0;
          gnt_d       = 3'b001 << owner_q;
          wdog_d      = '0;
        end
      end
      S_BUSY: begin
        wdog_d = wdog_q + WDOG_W'(1);
        // A completion arriving on the expiry cycle wins over the abort.
        if (burst_done_i || w_expire) begin
          state_d = S_IDLE;
          done_d  = 3'b001 << owner_q;
          rr_d    = (owner_q == 2'd2) ? 2'd0 : owner_q + 2'd1;
          owner_d = 2'd3;
          wdog_d  = '0;
          if (!burst_done_i) err_d = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        owner_d     = 2'd3;
        cmd_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= 2'd3;
      rr_q        <= 2'd0;
      cmd_valid_q <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      wdog_q      <= '0;
      err_q       <= 1'b0;
      gnt_q       <= 3'b000;
      done_q      <= 3'b000;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
      wdog_q      <= wdog_d;
      err_q       <= err_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
    end
  end

  assign gnt_o         = gnt_q;
  assign done_o        = done_q;
  assign owner_o       = owner_q;
  assign cmd_valid_o   = cmd_valid_q;
  assign cmd_wr_o      = cmd_wr_q;
  assign cmd_addr_o    = cmd_addr_q;
  assign cmd_len_o     = cmd_len_q;
  assign err_timeout_o = err_q;

endmodule
`default_nettype wire
